iob2wb_bridge: RTL and testbench

Parametrised IOb-native slave to Wishbone B3-classic master bridge, the reusable successor of the ad-hoc IOb/Wishbone glue around Wishbone peripherals. It accepts one IOb request at a time and runs a registered, single-outstanding Wishbone cycle. It returns read data and an error flag on the IOb side, and can optionally abort stalled cycles with a bus timeout. It sits between the system IOb interconnect and any Wishbone slave (Ethernet MAC register file, legacy cores).

---
 rtl/iob2wb_bridge_pkg.sv | 17 +
 rtl/iob2wb_bridge_if.sv | 41 ++++
 rtl/iob2wb_timeout.sv | 29 ++
 rtl/iob2wb_bridge.sv | 116 +++++++++++
 tb/tb_iob2wb_bridge.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/iob2wb_bridge_pkg.sv
// Shared types and helpers for the IOb to Wishbone bridge: FSM state encoding
// and the default Wishbone word-address width.
package iob2wb_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Word address width: byte address minus the byte-in-word offset bits.
  function automatic int unsigned wb_addr_w(input int unsigned addr_w,
                                            input int unsigned data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob2wb_bridge_if.sv
// IOb request/response plus Wishbone classic signals of the bridge.
// The slave modport is the bridge view; master is the system/bus side.
interface iob2wb_bridge_if
  import iob2wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WB_ADDR_W = wb_addr_w(ADDR_W, DATA_W)
);
  logic                   s_valid;
  logic [ADDR_W-1:0]      s_address;
  logic [DATA_W-1:0]      s_wdata;
  logic [DATA_W/8-1:0]    s_wstrb;
  logic [DATA_W-1:0]      s_rdata;
  logic                   s_ready;
  logic                   s_err;
  logic                   busy;
  logic                   overrun;
  logic [WB_ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]      wb_dat_o;
  logic [DATA_W/8-1:0]    wb_sel_o;
  logic                   wb_we_o;
  logic                   wb_cyc_o;
  logic                   wb_stb_o;
  logic [DATA_W-1:0]      wb_dat_i;
  logic                   wb_ack_i;
  logic                   wb_err_i;

  modport slave (
    input  s_valid, s_address, s_wdata, s_wstrb, wb_dat_i, wb_ack_i, wb_err_i,
    output s_rdata, s_ready, s_err, busy, overrun,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport master (
    output s_valid, s_address, s_wdata, s_wstrb, wb_dat_i, wb_ack_i, wb_err_i,
    input  s_rdata, s_ready, s_err, busy, overrun,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

endinterface

// File: rtl/iob2wb_timeout.sv
// Wishbone WAIT-state watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the count would reach TIMEOUT.
module iob2wb_timeout #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TIMEOUT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th stalled cycle so cyc drops right after it.
  assign o_expired = i_en && (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iob2wb_bridge.sv
// IOb slave to Wishbone B3-classic master, one outstanding cycle at a time.
// Define IOB2WB_TIMEOUT_EN to abort stalled cycles after TIMEOUT WAIT cycles.
module iob2wb_bridge
  import iob2wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned WB_ADDR_W = wb_addr_w(ADDR_W, DATA_W),
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  iob2wb_bridge_if.slave  bus
);

  localparam int unsigned SelW = DATA_W / 8;

  state_e               r_state;
  logic [WB_ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0]    r_wdat;
  logic [DATA_W-1:0]    r_rdata;
  logic [SelW-1:0]      r_sel;
  logic                 r_we;
  logic                 r_err;
  logic                 r_overrun;

  logic w_start;
  logic w_term;
  logic w_expired;

  assign w_start = (r_state == StIdle) && bus.s_valid;
  assign w_term  = bus.wb_ack_i || bus.wb_err_i;

`ifdef IOB2WB_TIMEOUT_EN
  iob2wb_timeout #(
    .TIMEOUT_W (TIMEOUT_W),
    .TIMEOUT   (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start),
    .i_en      ((r_state == StWait) && !w_term),
    .o_expired (w_expired)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT < (1 << TIMEOUT_W));
  assign w_expired    = 1'b0;
`endif

  if (ADDR_W > WB_ADDR_W) begin : g_unused_addr
    logic w_unused_addr;
    assign w_unused_addr = ^bus.s_address[ADDR_W-WB_ADDR_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_rdata   <= '0;
      r_sel     <= '0;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // Requests arriving while a transaction is in flight are dropped.
      if (bus.s_valid && (r_state != StIdle)) begin
        r_overrun <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (bus.s_valid) begin
            r_adr   <= bus.s_address[ADDR_W-1 -: WB_ADDR_W];
            r_wdat  <= bus.s_wdata;
            r_we    <= |bus.s_wstrb;
            r_sel   <= (|bus.s_wstrb) ? bus.s_wstrb : {SelW{1'b1}};
            r_state <= StWait;
          end
        end
        StWait: begin
          // A slave termination takes precedence over a coincident timeout.
          if (w_term) begin
            r_err   <= bus.wb_err_i;
            r_rdata <= (bus.wb_err_i || r_we) ? '0 : bus.wb_dat_i;
            r_state <= StResp;
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.wb_adr_o = r_adr;
  assign bus.wb_dat_o = r_wdat;
  assign bus.wb_sel_o = r_sel;
  assign bus.wb_we_o  = r_we;
  assign bus.wb_cyc_o = (r_state == StWait);
  assign bus.wb_stb_o = (r_state == StWait);
  assign bus.s_ready  = (r_state == StResp);
  assign bus.s_err    = r_err;
  assign bus.s_rdata  = r_rdata;
  assign bus.busy     = (r_state != StIdle);
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_iob2wb_bridge.sv
// Directed bench for iob2wb_bridge: stimulus pushes expected completions into
// a queue, a negedge monitor pops and compares on every s_ready pulse.
module tb_iob2wb_bridge;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned WAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  iob2wb_bridge_if #(.ADDR_W(AW), .DATA_W(DW), .WB_ADDR_W(WAW)) bus ();

  iob2wb_bridge #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .WB_ADDR_W (WAW),
    .TIMEOUT   (4),
    .TIMEOUT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every s_ready must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_s_ready", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("ready_cycle", 32'(cyc_cnt), 32'(e.cyc));
          check("s_rdata", bus.s_rdata, e.rdata);
          check("s_err", {31'd0, bus.s_err}, {31'd0, e.err});
        end
      end
    end
  end

  // One transaction; slave terminates in WAIT cycle k (k>=1).
  task automatic txn(input string tag, input logic [11:0] addr, input logic [3:0] strb,
                     input logic [31:0] wdata, input int k, input logic ack, input logic err,
                     input logic [31:0] rdat, input logic [31:0] exp_rdata,
                     input logic [9:0] exp_adr, input logic [3:0] exp_sel);
    exp_t e;
    tick();
    bus.s_valid   = 1'b1;
    bus.s_address = addr;
    bus.s_wstrb   = strb;
    bus.s_wdata   = wdata;
    e.rdata = exp_rdata;
    e.err   = err;
    e.cyc   = cyc_cnt + k + 1;
    q.push_back(e);
    tick();
    bus.s_valid = 1'b0;
    check({tag, "_cyc"}, {31'd0, bus.wb_cyc_o}, 32'd1);
    check({tag, "_stb"}, {31'd0, bus.wb_stb_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_adr"}, {22'd0, bus.wb_adr_o}, {22'd0, exp_adr});
    check({tag, "_sel"}, {28'd0, bus.wb_sel_o}, {28'd0, exp_sel});
    check({tag, "_we"}, {31'd0, bus.wb_we_o}, {31'd0, |strb});
    if (strb != 4'd0) check({tag, "_dat"}, bus.wb_dat_o, wdata);
    repeat (k - 1) tick();
    check({tag, "_adr_stable"}, {22'd0, bus.wb_adr_o}, {22'd0, exp_adr});
    bus.wb_ack_i = ack;
    bus.wb_err_i = err;
    bus.wb_dat_i = rdat;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = '0;
    check({tag, "_cyc_resp"}, {31'd0, bus.wb_cyc_o}, 32'd0);
    tick();
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   n_hi;
    bus.s_valid   = 1'b0;
    bus.s_address = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.wb_dat_i  = '0;
    bus.wb_ack_i  = 1'b0;
    bus.wb_err_i  = 1'b0;
    #1;
    check("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    check("rst_s_err", {31'd0, bus.s_err}, 32'd0);
    check("rst_s_rdata", bus.s_rdata, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    check("rst_cyc_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    check("rst_we", {31'd0, bus.wb_we_o}, 32'd0);
    check("rst_adr", {22'd0, bus.wb_adr_o}, 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    check("rst_sel", {28'd0, bus.wb_sel_o}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;

    txn("rd", 12'h008, 4'h0, 32'h0, 2, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 10'h002, 4'hF);
    txn("wr", 12'h014, 4'h3, 32'h12345678, 1, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0, 10'h005, 4'h3);
    txn("ackerr", 12'h020, 4'h0, 32'h0, 1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h0, 10'h008, 4'hF);
    txn("wrerr", 12'hFFC, 4'hC, 32'hA5A55A5A, 3, 1'b0, 1'b1, 32'h11111111, 32'h0, 10'h3FF, 4'hC);

`ifdef IOB2WB_TIMEOUT_EN
    tick();
    bus.s_valid   = 1'b1;
    bus.s_address = 12'h200;
    bus.s_wstrb   = 4'h0;
    e.rdata = 32'h0;
    e.err   = 1'b1;
    e.cyc   = cyc_cnt + 5;
    q.push_back(e);
    tick();
    bus.s_valid = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.wb_cyc_o) n_hi++;
      tick();
    end
    check("timeout_cyc_cycles", 32'(n_hi), 32'd4);
    txn("after_to", 12'h204, 4'h0, 32'h0, 1, 1'b1, 1'b0, 32'h00C0FFEE, 32'h00C0FFEE, 10'h081,
        4'hF);
`else
    n_hi = 0;
    txn("hold", 12'h0FC, 4'h0, 32'h0, 21, 1'b1, 1'b0, 32'h0BADF00D, 32'h0BADF00D, 10'h03F, 4'hF);
`endif

    // Overrun: second request one cycle after the first is dropped.
    tick();
    bus.s_valid   = 1'b1;
    bus.s_address = 12'h030;
    bus.s_wstrb   = 4'h0;
    e.rdata = 32'hA5A50001;
    e.err   = 1'b0;
    e.cyc   = cyc_cnt + 3;
    q.push_back(e);
    tick();
    bus.s_address = 12'h040;
    bus.s_wstrb   = 4'hF;
    tick();
    bus.s_valid = 1'b0;
    check("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    check("ovr_adr_kept", {22'd0, bus.wb_adr_o}, 32'h00C);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hA5A50001;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    n_hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.wb_cyc_o) n_hi++;
    end
    check("ovr_no_second_cycle", 32'(n_hi), 32'd0);
    check("ovr_sticky", {31'd0, bus.overrun}, 32'd1);

    // Async reset during WAIT: cycle is lost, no s_ready.
    tick();
    bus.s_valid   = 1'b1;
    bus.s_address = 12'h100;
    bus.s_wstrb   = 4'h0;
    tick();
    bus.s_valid = 1'b0;
    check("arst_pre_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_cyc_stb", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'd0);
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_overrun", {31'd0, bus.overrun}, 32'd0);
    tick();
    rst = 1'b0;
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h77777777;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    repeat (2) tick();
    txn("post_rst", 12'h104, 4'h0, 32'h0, 2, 1'b1, 1'b0, 32'h13572468, 32'h13572468, 10'h041,
        4'hF);

    repeat (3) tick();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
